// File: rtl/music_pkg.sv
// Shared widths, types and constants for the song path of the music player.
package music_pkg;

  localparam int IDX_W  = 5;
  localparam int NOTE_W = 6;
  localparam int DUR_W  = 6;
  localparam int SONG_W = 2;
  localparam int ADDR_W = SONG_W + IDX_W;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'((1 << IDX_W) - 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    ISSUE,
    WAIT_NOTE,
    DONE
  } reader_state_e;

  typedef struct packed {
    logic [NOTE_W-1:0] note;
    logic [DUR_W-1:0]  duration;
  } rom_word_t;

endpackage

// File: rtl/note_idx_counter.sv
// Note index within the current song: clearable, saturates at the last entry
// so the index never wraps back to the start of the song.
module note_idx_counter
  import music_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  output logic [IDX_W-1:0] count,
  output logic             is_last
);

  logic [IDX_W-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc && (count_q != LAST_IDX)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count   = count_q;
  assign is_last = (count_q == LAST_IDX);

endmodule

// File: rtl/song_reader.sv
// Walks the selected song in the song ROM and hands notes to the note player.
// Optional macro SONG_END_MARKER_EN: a duration==0 word ends the song early.
module song_reader
  import music_pkg::*;
#(
  parameter int ROM_LAT = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    play,
  input  logic                    reset_player,
  input  logic [SONG_W-1:0]       song,
  output logic [ADDR_W-1:0]       rom_addr,
  input  logic [NOTE_W+DUR_W-1:0] rom_data,
  output logic [NOTE_W-1:0]       note,
  output logic [DUR_W-1:0]        duration,
  output logic                    new_note,
  input  logic                    note_done,
  output logic                    song_done
);

  localparam logic [1:0] LAT_LOAD = 2'(ROM_LAT);

  reader_state_e     state_d, state_q;
  logic [1:0]        wait_d, wait_q;
  logic [NOTE_W-1:0] note_d, note_q;
  logic [DUR_W-1:0]  duration_d, duration_q;
  logic              new_note_d, new_note_q;
  logic              song_done_d, song_done_q;

  logic              idx_clear, idx_inc, idx_last;
  logic [IDX_W-1:0]  note_idx;
  rom_word_t         word;
  logic              is_marker;

  note_idx_counter u_idx (
    .clk     (clk),
    .reset   (reset),
    .clear   (idx_clear),
    .inc     (idx_inc),
    .count   (note_idx),
    .is_last (idx_last)
  );

  assign rom_addr = {song, note_idx};
  assign word     = rom_word_t'(rom_data);

`ifdef SONG_END_MARKER_EN
  assign is_marker = (word.duration == '0);
`else
  assign is_marker = 1'b0;
`endif

  // reset_player overrides every state, including a note_done in the same cycle
  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    note_d      = note_q;
    duration_d  = duration_q;
    new_note_d  = 1'b0;
    song_done_d = 1'b0;
    idx_clear   = 1'b0;
    idx_inc     = 1'b0;

    if (reset_player) begin
      state_d    = IDLE;
      wait_d     = '0;
      note_d     = '0;
      duration_d = '0;
      idx_clear  = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (play) begin
            state_d = FETCH;
            wait_d  = LAT_LOAD;
          end
        end
        FETCH: begin
          if (wait_q <= 2'd1) begin
            state_d = ISSUE;
          end else begin
            wait_d = wait_q - 2'd1;
          end
        end
        ISSUE: begin
          if (is_marker) begin
            state_d     = DONE;
            song_done_d = 1'b1;
          end else begin
            note_d     = word.note;
            duration_d = word.duration;
            new_note_d = 1'b1;
            state_d    = WAIT_NOTE;
          end
        end
        WAIT_NOTE: begin
          if (note_done) begin
            if (idx_last) begin
              state_d     = DONE;
              song_done_d = 1'b1;
            end else begin
              idx_inc = 1'b1;
              if (play) begin
                state_d = FETCH;
                wait_d  = LAT_LOAD;
              end else begin
                state_d = IDLE;
              end
            end
          end
        end
        DONE: begin
          state_d = DONE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      wait_q      <= '0;
      note_q      <= '0;
      duration_q  <= '0;
      new_note_q  <= 1'b0;
      song_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      note_q      <= note_d;
      duration_q  <= duration_d;
      new_note_q  <= new_note_d;
      song_done_q <= song_done_d;
    end
  end

  assign note      = note_q;
  assign duration  = duration_q;
  assign new_note  = new_note_q;
  assign song_done = song_done_q;

endmodule

// File: tb/tb_song_reader.sv
// Self-checking bench for song_reader: random ROM contents, directed play/pause/end scenarios.
module tb_song_reader;
  import music_pkg::*;

  localparam int ROM_LAT  = 1;
  localparam int LAT      = ROM_LAT + 2;
  localparam int SONG_LEN = 1 << IDX_W;
  localparam int WORD_W   = NOTE_W + DUR_W;

  logic              clk = 1'b0;
  logic              reset;
  logic              play;
  logic              reset_player;
  logic              note_done;
  logic [SONG_W-1:0] song;
  logic [ADDR_W-1:0] rom_addr;
  logic [WORD_W-1:0] rom_data = '0;
  logic [NOTE_W-1:0] note;
  logic [DUR_W-1:0]  duration;
  logic              new_note;
  logic              song_done;

  logic [WORD_W-1:0] rom [0:(1<<ADDR_W)-1];
  logic [WORD_W-1:0] last_word;

  int checks   = 0;
  int failures = 0;
  int exp_idx  = 0;

  song_reader #(.ROM_LAT(ROM_LAT)) dut (
    .clk          (clk),
    .reset        (reset),
    .play         (play),
    .reset_player (reset_player),
    .song         (song),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .note         (note),
    .duration     (duration),
    .new_note     (new_note),
    .note_done    (note_done),
    .song_done    (song_done)
  );

  always #5 clk = ~clk;

  // Synchronous song ROM with one cycle of read latency
  always @(posedge clk) rom_data <= rom[rom_addr];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic pl, input logic nd, input logic rp);
    play         = pl;
    note_done    = nd;
    reset_player = rp;
  endtask

  // Expect the note at (song, exp_idx) to be offered exactly LAT cycles after the stimulus
  task automatic waitForNote(input string tag);
    int n = 0;
    logic [WORD_W-1:0] exp_word;
    exp_word = rom[int'(song) * SONG_LEN + exp_idx];
    while (new_note !== 1'b1 && n < 20) begin
      tick();
      n++;
      note_done = 1'b0;
    end
    checkOutput({tag, "_latency"}, 32'(n), 32'(LAT));
    checkOutput({tag, "_note"}, 32'(note), 32'(exp_word[WORD_W-1:DUR_W]));
    checkOutput({tag, "_duration"}, 32'(duration), 32'(exp_word[DUR_W-1:0]));
    checkOutput({tag, "_rom_addr"}, 32'(rom_addr), 32'(int'(song) * SONG_LEN + exp_idx));
    last_word = exp_word;
    tick();
    checkOutput({tag, "_pulse_width"}, 32'(new_note), 32'(0));
  endtask

  // Watch a window: no new_note, and song_done either absent or a single pulse at sd_cycle
  task automatic quietFor(input string tag, input int cycles, input int sd_cycle);
    int nn = 0;
    int sd = 0;
    int first = -1;
    for (int c = 1; c <= cycles; c++) begin
      tick();
      note_done = 1'b0;
      if (new_note === 1'b1) nn++;
      if (song_done === 1'b1) begin
        sd++;
        if (first < 0) first = c;
      end
    end
    checkOutput({tag, "_new_note_count"}, 32'(nn), 32'(0));
    checkOutput({tag, "_song_done_count"}, 32'(sd), 32'((sd_cycle < 0) ? 0 : 1));
    checkOutput({tag, "_song_done_cycle"}, 32'(first), 32'(sd_cycle));
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    song  = 2'd2;
    applyStimulus(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < (1 << ADDR_W); i++) begin
      rom[i] = {6'($urandom), 6'($urandom_range(1, 63))};
    end
    rom[2 * SONG_LEN]     = {6'd12, 6'd8};
    rom[1 * SONG_LEN + 4] = {6'($urandom), 6'd0};

    repeat (3) tick();
    checkOutput("reset_note", 32'(note), 32'(0));
    checkOutput("reset_duration", 32'(duration), 32'(0));
    checkOutput("reset_new_note", 32'(new_note), 32'(0));
    checkOutput("reset_song_done", 32'(song_done), 32'(0));
    reset = 1'b0;
    checkOutput("reset_rom_addr", 32'(rom_addr), 32'h40);

    exp_idx = 0;
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitForNote("play_start");

    for (int k = 0; k < 5; k++) begin
      repeat ($urandom_range(0, 4)) tick();
      exp_idx++;
      applyStimulus(1'b1, 1'b1, 1'b0);
      waitForNote("sequence");
    end

    applyStimulus(1'b0, 1'b1, 1'b0);
    exp_idx = 6;
    quietFor("pause", 50, -1);
    checkOutput("pause_rom_addr", 32'(rom_addr), 32'h46);
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitForNote("resume");

    for (int k = 0; k < 4; k++) begin
      repeat ($urandom_range(0, 4)) tick();
      exp_idx++;
      applyStimulus(1'b1, 1'b1, 1'b0);
      waitForNote("to_idx10");
    end

    applyStimulus(1'b0, 1'b1, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("prio_rom_addr", 32'(rom_addr), 32'h40);
    checkOutput("prio_note", 32'(note), 32'(0));
    checkOutput("prio_duration", 32'(duration), 32'(0));
    exp_idx = 0;
    quietFor("prio", 10, -1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitForNote("prio_restart");

    exp_idx = 1;
    applyStimulus(1'b1, 1'b1, 1'b0);
    tick();
    note_done = 1'b0;
    #2 reset = 1'b1;
    #1;
    checkOutput("async_note", 32'(note), 32'(0));
    checkOutput("async_duration", 32'(duration), 32'(0));
    checkOutput("async_new_note", 32'(new_note), 32'(0));
    checkOutput("async_rom_addr", 32'(rom_addr), 32'h40);
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick();
    reset = 1'b0;
    quietFor("post_reset", 5, -1);

    exp_idx = 0;
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitForNote("walk_first");
    for (int k = 1; k < SONG_LEN; k++) begin
      repeat ($urandom_range(0, 2)) tick();
      exp_idx = k;
      applyStimulus(1'b1, 1'b1, 1'b0);
      waitForNote("walk");
    end
    applyStimulus(1'b1, 1'b1, 1'b0);
    quietFor("end_of_song", 10, 1);
    checkOutput("end_rom_addr", 32'(rom_addr), 32'h5F);
    applyStimulus(1'b1, 1'b1, 1'b0);
    quietFor("done_hold", 10, -1);

    song = 2'd1;
    applyStimulus(1'b0, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("restart_rom_addr", 32'(rom_addr), 32'h20);

    exp_idx = 0;
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitForNote("song1_first");
    for (int k = 1; k < 4; k++) begin
      exp_idx = k;
      applyStimulus(1'b1, 1'b1, 1'b0);
      waitForNote("song1");
    end
    exp_idx = 4;
    applyStimulus(1'b1, 1'b1, 1'b0);
`ifdef SONG_END_MARKER_EN
    quietFor("marker", 10, LAT);
    checkOutput("marker_note_kept", 32'(note), 32'(last_word[WORD_W-1:DUR_W]));
    checkOutput("marker_duration_kept", 32'(duration), 32'(last_word[DUR_W-1:0]));
`else
    waitForNote("zero_duration");
    checkOutput("zero_duration_value", 32'(duration), 32'(0));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/song_reader.md
Name: song_reader

Overview:
- Downstream of the music-player control unit.
- Consumes its play / reset_player / song outputs and returns song_done to it.
- Walks the selected song's entries in an external song ROM and hands one note at a time to the note player using a new_note / note_done handshake.
- Pauses between notes while play is low.

Parameters:
- IDX_W, 5: note-index width; each song holds 2^IDX_W entries.
- NOTE_W, 6: note-code width.
- DUR_W, 6: duration width.
- ROM_LAT, 1: ROM read latency in cycles. Legal values are 1 or 2.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- play  in  1  level from control unit; 1 = running, 0 = paused
- reset_player  in  1  synchronous restart of the current song, index back to 0
- song  in  2  selected song number
- rom_addr  out  2+IDX_W  ROM address, equal to {song, note_idx}
- rom_data  in  NOTE_W+DUR_W  ROM word {note, duration}, valid ROM_LAT cycles after rom_addr
- note  out  NOTE_W  current note code, registered
- duration  out  DUR_W  current duration, registered
- new_note  out  1  one-cycle pulse: note/duration are valid and must be started
- note_done  in  1  one-cycle pulse from the note player: current note finished
- song_done  out  1  one-cycle pulse: last entry of the song has finished

Behaviour:
- Reset (asynchronous): state=IDLE, note_idx=0, note=0, duration=0, new_note=0, song_done=0.
- rom_addr is combinational {song, note_idx}.
- States: IDLE, FETCH, ISSUE, WAIT_NOTE, DONE.
- IDLE:
  - play=1 -> FETCH, with the wait counter loaded to ROM_LAT.
  - Otherwise hold.
- FETCH:
  - Count down ROM_LAT cycles, then -> ISSUE.
  - If play drops during FETCH, finish the fetch anyway.
- ISSUE (one cycle):
  - Register note and duration from rom_data.
  - new_note=1 in the cycle after ISSUE, i.e. aligned with the new note/duration values.
  - Then -> WAIT_NOTE.
- WAIT_NOTE:
  - On note_done with note_idx == 2^IDX_W-1 -> DONE; song_done pulses high for exactly one cycle on entry.
  - On note_done otherwise: note_idx+1, then -> FETCH if play=1, else -> IDLE (paused).
  - note_done is accepted regardless of play.
- DONE:
  - Hold; no further new_note or song_done.
  - Leave only via reset_player or reset.
- note_done outside WAIT_NOTE is ignored.
- Latency:
  - Play rising in IDLE to new_note high is ROM_LAT+2 cycles.
  - note_done to the next new_note is ROM_LAT+2 cycles when play=1.
- reset_player:
  - Has priority over every other input, including a coincident note_done.
  - Next state: note_idx=0, state=IDLE, note/duration cleared to 0, new_note=0, song_done=0.
  - Any in-flight fetch is discarded.
- Changing song without reset_player:
  - The next fetch uses the new song at the current index.
  - The control unit always pairs a song change with reset_player.
- note_idx never wraps. The end of the song is handled only by the DONE state.
- Registered outputs: note, duration, new_note, song_done. None is combinational from inputs.

Optional Feature:
- Macro: SONG_END_MARKER_EN.
- Defined: in ISSUE, a rom_data word with duration==0 is an end marker.
  - No new_note is issued and note/duration are not updated.
  - The block goes directly to DONE and song_done pulses next cycle.
- Undefined: a duration==0 entry is issued as an ordinary note with new_note. The song ends only after index 2^IDX_W-1.

Decomposition:
- Shared package music_pkg holds:
  - Widths: IDX_W, NOTE_W, DUR_W, song width 2.
  - The reader state-enum typedef.
  - Constant LAST_IDX = 2^IDX_W-1.
  - rom_word typedef {note, duration}.
- One natural sub-module, note_idx_counter: IDX_W-bit counter with async reset, synchronous clear, increment enable and an is_last flag.
- FSM, output registers and the ROM-latency wait counter stay in song_reader.

Test Plan:
- Play start: reset, song=2, ROM[{2,0}]={note 12, dur 8}, play=1 -> rom_addr=0x40; new_note pulses 1 cycle at cycle 3 with note=12, duration=8.
- Sequencing: pulse note_done 3 times with play=1 -> rom_addr advances 0x41, 0x42, 0x43; each new_note arrives ROM_LAT+2 cycles after note_done.
- Pause: play=0 before note_done at idx 5 -> idx becomes 6, no new_note for 50 cycles. Then play=1 -> new_note with ROM[{song,6}] after 3 cycles.
- End of song: note_done at idx 31 -> single song_done pulse, stays DONE. Further note_done produces no output until reset_player, which returns idx to 0.
- Priority: reset_player and note_done in the same cycle at idx 10 -> idx=0, IDLE, no new_note. Async reset asserted during FETCH clears all outputs immediately.
- SONG_END_MARKER_EN defined: ROM[{1,4}] has dur=0 -> after the 4th note_done, song_done pulses with no 5th new_note. Undefined: new_note issued with duration=0.
